uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO byte capacity (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, meaning FIFO address width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_en  input  1  write strobe; one byte per high cycle.
REQ-006 The block SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 The block SHALL have port full  output  1  high when count == DEPTH.
REQ-008 The block SHALL have port empty  output  1  high when count == 0.
REQ-009 The block SHALL have port count  output  AW+1  bytes currently stored.
REQ-010 The block SHALL have port overflow  output  1  one-cycle pulse when a write is rejected.
REQ-011 The block SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-012 The block SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-013 The block SHALL have port tx_done  input  1  one-cycle completion pulse from the transmitter.
REQ-014 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FIFO SHALL be circular: write pointer and read pointer are AW bits wide, wrap from DEPTH-1 to 0, and count tracks occupancy.
REQ-016 A write SHALL be accepted when wr_en=1 and full=0, where full is sampled before the edge; the byte is stored at wr_ptr, and wr_ptr and count are incremented.
REQ-017 A write with wr_en=1 and full=1 SHALL be dropped, with no state change, and overflow=1 on the next cycle only; a same-cycle pop SHALL NOT rescue the write.
REQ-018 The FSM SHALL have states IDLE, LOAD, START and WAIT.
REQ-019 IDLE: if count>0, the block SHALL pop the head into tx_data, increment rd_ptr, decrement count and go to LOAD; otherwise it stays in IDLE.
REQ-020 LOAD: the block SHALL wait one cycle for tx_data to settle and then go to START.
REQ-021 START: tx_start SHALL be 1 for exactly this cycle, and the FSM then goes to WAIT.
REQ-022 WAIT: the FSM SHALL hold until tx_done=1 and then return to IDLE; tx_data SHALL remain stable from LOAD until WAIT exits.
REQ-023 A tx_done pulse arriving in any state other than WAIT SHALL be ignored.
REQ-024 A simultaneous accepted write and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-025 A write into an empty queue while in IDLE SHALL NOT be popped in the same cycle; latency from the wr_en edge to tx_start=1 SHALL be 3 cycles.
REQ-026 Back-to-back bytes: once tx_done is seen, the next tx_start SHALL follow 3 cycles later if the queue is non-empty.
REQ-027 full, empty and count SHALL be combinational from registered state.

Reset
REQ-028 Asserting rst at any time SHALL immediately force: FSM=IDLE, pointers=0, count=0, tx_data=0x00, tx_start=0, overflow=0, busy=0; any queued or in-flight bytes SHALL be discarded.
REQ-029 FIFO storage contents SHALL NOT require reset.

Configuration
REQ-030 Macro UART_TX_CRLF_EN defined: when the popped byte is 0x0A, the block SHALL first send 0x0D (LOAD/START/WAIT), then send 0x0A through a further LOAD/START/WAIT without a second pop, and busy SHALL stay high throughout.
REQ-031 Macro UART_TX_CRLF_EN undefined: all bytes SHALL be sent verbatim, and no extra state or logic SHALL exist.

Verification
REQ-032 Reset, then write 0x41 -> tx_start pulses 3 cycles later with tx_data=0x41; after tx_done, busy=0 and empty=1.
REQ-033 Burst-write 0x00..0x0F (DEPTH=16) while tx_done is held off -> 16 pulses of tx_start, in order, each following tx_done; count peaks at 15 and full never rejects a byte.
REQ-034 Fill to full with the FSM stalled in WAIT, then write 0x55 -> overflow pulses for 1 cycle, count stays 16, and 0x55 is never transmitted.
REQ-035 Assert rst while in WAIT with 5 bytes queued -> outputs take reset values at once; after release, no tx_start occurs without a new write.
REQ-036 With UART_TX_CRLF_EN defined, write 0x0A -> tx_data sequence 0x0D then 0x0A, 2 tx_start pulses, 1 pop; without the macro -> a single 0x0A.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte FIFO feeding a UART transmitter through an IDLE/LOAD/START/WAIT handshake FSM.
// Define UART_TX_CRLF_EN to expand each 0x0A into the pair 0x0D, 0x0A.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
  state_t state, state_nx, after_wait;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
`ifdef UART_TX_CRLF_EN
  logic lf_pending;
  assign after_wait = lf_pending ? LOAD : IDLE;
`else
  assign after_wait = IDLE;
`endif
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign push     = wr_en && !full;
  assign pop      = state == IDLE && !empty;
  assign tx_start = state == START;
  assign busy     = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (pop ? LOAD : IDLE) :
               state == LOAD  ? START :
               state == START ? WAIT :
               (tx_done ? after_wait : WAIT);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // Storage is never reset; only pointers and count define its valid contents.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      tx_data    <= 8'h00;
`ifdef UART_TX_CRLF_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      overflow <= wr_en && full;
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
`ifdef UART_TX_CRLF_EN
      if (pop && mem[rd_ptr] == 8'h0A) begin
        tx_data    <= 8'h0D;
        lf_pending <= 1'b1;
      end
      if (state == WAIT && tx_done && lf_pending) begin
        tx_data    <= 8'h0A;
        lf_pending <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed and random stimulus against a queue-based reference model of uart_tx_queue.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  logic clk, rst, wr_en, tx_done;
  logic [7:0] wr_data, tx_data;
  logic full, empty, overflow, tx_start, busy;
  logic [AW:0] count;
  int n_tests, n_fail, peak;
  logic [7:0] q[$];
  logic [7:0] m_tx;
  int m_cd;
  bit m_wait, m_lf, m_ovf;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tx = 8'h00; m_cd = 0; m_wait = 0; m_lf = 0; m_ovf = 0;
  endtask

  // After a pop the byte is announced two cycles later, then the model waits for tx_done.
  task automatic model_edge(input logic we, input logic [7:0] wd, input logic td);
    bit was_full, was_busy;
    logic [7:0] b;
    was_full = q.size() == DEPTH;
    was_busy = m_cd != 0 || m_wait;
    m_ovf = we && was_full;
    if (!was_busy && q.size() > 0) begin
      b = q.pop_front();
      m_cd = 2;
      m_tx = b;
`ifdef UART_TX_CRLF_EN
      if (b == 8'h0A) begin m_tx = 8'h0D; m_lf = 1; end
`endif
    end else if (m_cd == 2) m_cd = 1;
    else if (m_cd == 1) begin m_cd = 0; m_wait = 1; end
    else if (m_wait && td) begin
      m_wait = 0;
      if (m_lf) begin m_lf = 0; m_tx = 8'h0A; m_cd = 2; end
    end
    if (we && !was_full) q.push_back(wd);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".tx_start"}, 32'(tx_start), 32'(m_cd == 1));
    check({tag, ".busy"}, 32'(busy), 32'(m_cd != 0 || m_wait));
    check({tag, ".tx_data"}, 32'(tx_data), 32'(m_tx));
  endtask

  task automatic step(input string tag, input logic we, input logic [7:0] wd, input logic td);
    @(negedge clk);
    check_outputs(tag);
    if (32'(count) > peak) peak = 32'(count);
    wr_en = we; wr_data = wd; tx_done = td;
    @(posedge clk);
    model_edge(we, wd, td);
  endtask

  task automatic run(input string tag, input int n, input int p_wr, input int p_done);
    for (int i = 0; i < n; i++)
      step(tag, $urandom_range(99) < p_wr, 8'($urandom), $urandom_range(99) < p_done);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; peak = 0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    // Single byte: start pulse three cycles after the write cycle
    step("one", 1'b1, 8'h41, 1'b0);
    repeat (6) step("one", 1'b0, 8'h00, 1'b0);
    step("one", 1'b0, 8'h00, 1'b1);
    repeat (3) step("one_idle", 1'b0, 8'h00, 1'b0);
    // Burst while the transmitter is slow
    peak = 0;
    for (int i = 0; i < 16; i++) step("burst", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 250; i++) step("burst", 1'b0, 8'h00, i % 5 == 0);
    check("burst_peak", 32'(peak), 32'd15);
    // Fill to full while stalled in WAIT, then overrun
    for (int i = 0; i < 17; i++) step("fill", 1'b1, 8'(8'h80 + i), 1'b0);
    step("fill", 1'b1, 8'h55, 1'b0);
    @(negedge clk);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'(DEPTH));
    step("ovf_drop", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 300; i++) step("drain", 1'b0, 8'h00, $urandom_range(2) == 0);
    // Asynchronous reset while in WAIT with bytes queued
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0);
    repeat (4) step("pre_rst", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) step("post_rst", 1'b0, 8'h00, 1'b1);
    // Line feed handling, alone and between other bytes
    step("lf", 1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 30; i++) step("lf", 1'b0, 8'h00, i % 3 == 0);
    step("lf_mix", 1'b1, 8'h41, 1'b0);
    step("lf_mix", 1'b1, 8'h0A, 1'b0);
    step("lf_mix", 1'b1, 8'h42, 1'b0);
    for (int i = 0; i < 60; i++) step("lf_mix", 1'b0, 8'h00, i % 4 == 0);
    // Random traffic with varying load and spurious completion pulses
    run("rand_hi", 1500, 70, 30);
    run("rand_lo", 1500, 15, 40);
    for (int i = 0; i < 300; i++) step("rand_lf", $urandom_range(3) == 0, $urandom_range(1) ? 8'h0A : 8'($urandom), $urandom_range(2) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
